candy_div_ctrl: RTL and testbench

Sequencer and arbiter for the shared 24-bit `div` unit in the `candy` core. It accepts divide requests from two requesters with round-robin fairness and drives the divider's `start`/`annul` handshake. It short-circuits divide-by-zero, aborts on requester cancel or watchdog timeout, and returns each result on a shared, tagged response bus.

---
 rtl/candy_div_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_candy_div_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/candy_div_ctrl.sv
// Sequencer/arbiter for the shared candy divider: round-robin grant between two
// requesters, start/annul handshake, divide-by-zero bypass, watchdog and tagged response.
module candy_div_ctrl #(
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_signed,
    input  logic [DATA_W-1:0] req0_dividend,
    input  logic [DATA_W-1:0] req0_divisor,
    input  logic              req0_cancel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_signed,
    input  logic [DATA_W-1:0] req1_dividend,
    input  logic [DATA_W-1:0] req1_divisor,
    input  logic              req1_cancel,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_quotient,
    output logic [DATA_W-1:0] resp_remainder,
    output logic              resp_dz,
    output logic              resp_timeout,
    output logic              busy_o,
    output logic              div_start_o,
    output logic              div_annul_o,
    output logic              div_signed_o,
    output logic [DATA_W-1:0] div_opdata1_o,
    output logic [DATA_W-1:0] div_opdata2_o,
    input  logic              div_ready_i,
    input  logic [DATA_W-1:0] div_quotient_i,
    input  logic [DATA_W-1:0] div_remainder_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ANNUL = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              pend_q, pend_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;
    logic              div_start_q, div_start_d;
    logic              div_annul_q, div_annul_d;
    logic              div_signed_q, div_signed_d;
    logic [DATA_W-1:0] div_op1_q, div_op1_d;
    logic [DATA_W-1:0] div_op2_q, div_op2_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_quo_q, resp_quo_d;
    logic [DATA_W-1:0] resp_rem_q, resp_rem_d;
    logic              resp_dz_q, resp_dz_d;
    logic              resp_to_q, resp_to_d;

    logic              grant_any_s;
    logic              grant_id_s;
    logic              sel_signed_s;
    logic [DATA_W-1:0] sel_dividend_s;
    logic [DATA_W-1:0] sel_divisor_s;
    logic              owner_cancel_s;

    // Round-robin arbitration: on contention the requester that did not win last time goes.
    always_comb begin
        grant_any_s = req0_valid | req1_valid;
        grant_id_s  = req1_valid & (~req0_valid | ~last_grant_q);
        if (grant_id_s) begin
            sel_signed_s   = req1_signed;
            sel_dividend_s = req1_dividend;
            sel_divisor_s  = req1_divisor;
        end else begin
            sel_signed_s   = req0_signed;
            sel_dividend_s = req0_dividend;
            sel_divisor_s  = req0_divisor;
        end
        if (owner_q) begin
            owner_cancel_s = req1_cancel;
        end else begin
            owner_cancel_s = req0_cancel;
        end
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        pend_d       = pend_q;
        wd_cnt_d     = wd_cnt_q;
        div_start_d  = 1'b0;
        div_annul_d  = 1'b0;
        div_signed_d = div_signed_q;
        div_op1_d    = div_op1_q;
        div_op2_d    = div_op2_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_quo_d   = resp_quo_q;
        resp_rem_d   = resp_rem_q;
        resp_dz_d    = resp_dz_q;
        resp_to_d    = resp_to_q;

        case (state_q)
            S_IDLE: begin
                if (grant_any_s) begin
                    owner_d      = grant_id_s;
                    last_grant_d = grant_id_s;
                    div_signed_d = sel_signed_s;
                    div_op1_d    = sel_dividend_s;
                    div_op2_d    = sel_divisor_s;
                    wd_cnt_d     = 8'd0;
                    pend_d       = 1'b0;
                    if (sel_divisor_s == {DATA_W{1'b0}}) begin
                        // Divide-by-zero never touches the divider.
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_id_d    = grant_id_s;
                        resp_quo_d   = {DATA_W{1'b1}};
                        resp_rem_d   = sel_dividend_s;
                        resp_dz_d    = 1'b1;
                        resp_to_d    = 1'b0;
                    end else begin
                        state_d     = S_BUSY;
                        div_start_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (owner_cancel_s) begin
                    state_d     = S_ANNUL;
                    div_annul_d = 1'b1;
                    pend_d      = 1'b0;
                end else if (div_ready_i) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = owner_q;
                    resp_quo_d   = div_quotient_i;
                    resp_rem_d   = div_remainder_i;
                    resp_dz_d    = 1'b0;
                    resp_to_d    = 1'b0;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d     = S_ANNUL;
                    div_annul_d = 1'b1;
                    pend_d      = 1'b1;
                end else begin
                    div_start_d = 1'b1;
                    wd_cnt_d    = wd_cnt_q + 8'd1;
                end
            end
            S_ANNUL: begin
                if (pend_q) begin
                    state_d      = S_RESP;
                    pend_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_id_d    = owner_q;
                    resp_quo_d   = {DATA_W{1'b0}};
                    resp_rem_d   = {DATA_W{1'b0}};
                    resp_dz_d    = 1'b0;
                    resp_to_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; last_grant resets to 1 so req0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            pend_q       <= 1'b0;
            wd_cnt_q     <= 8'd0;
            div_start_q  <= 1'b0;
            div_annul_q  <= 1'b0;
            div_signed_q <= 1'b0;
            div_op1_q    <= {DATA_W{1'b0}};
            div_op2_q    <= {DATA_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_quo_q   <= {DATA_W{1'b0}};
            resp_rem_q   <= {DATA_W{1'b0}};
            resp_dz_q    <= 1'b0;
            resp_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            pend_q       <= pend_d;
            wd_cnt_q     <= wd_cnt_d;
            div_start_q  <= div_start_d;
            div_annul_q  <= div_annul_d;
            div_signed_q <= div_signed_d;
            div_op1_q    <= div_op1_d;
            div_op2_q    <= div_op2_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_quo_q   <= resp_quo_d;
            resp_rem_q   <= resp_rem_d;
            resp_dz_q    <= resp_dz_d;
            resp_to_q    <= resp_to_d;
        end
    end

    assign req0_ready     = (state_q == S_IDLE) & req0_valid & ~grant_id_s;
    assign req1_ready     = (state_q == S_IDLE) & req1_valid & grant_id_s;
    assign busy_o         = (state_q != S_IDLE);
    assign div_start_o    = div_start_q;
    assign div_annul_o    = div_annul_q;
    assign div_signed_o   = div_signed_q;
    assign div_opdata1_o  = div_op1_q;
    assign div_opdata2_o  = div_op2_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quo_q;
    assign resp_remainder = resp_rem_q;
    assign resp_dz        = resp_dz_q;
    assign resp_timeout   = resp_to_q;

endmodule

// File: tb/tb_candy_div_ctrl.sv
// Self-checking bench for candy_div_ctrl: vector table plus hand-written cancel,
// timeout, reset and contention sequences, with a response scoreboard.
module tb_candy_div_ctrl;
    localparam int W  = 24;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_signed, req0_cancel;
    logic [W-1:0] req0_dividend, req0_divisor;
    logic         req1_valid, req1_ready, req1_signed, req1_cancel;
    logic [W-1:0] req1_dividend, req1_divisor;
    logic         resp_valid, resp_id, resp_dz, resp_timeout;
    logic [W-1:0] resp_quotient, resp_remainder;
    logic         busy_o, div_start_o, div_annul_o, div_signed_o;
    logic [W-1:0] div_opdata1_o, div_opdata2_o;
    logic         div_ready_i;
    logic [W-1:0] div_quotient_i, div_remainder_i;

    always #5 clk = ~clk;

    candy_div_ctrl #(.DATA_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor), .req0_cancel(req0_cancel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor), .req1_cancel(req1_cancel),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder), .resp_dz(resp_dz), .resp_timeout(resp_timeout),
        .busy_o(busy_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
        .div_ready_i(div_ready_i), .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         to;
    } exp_t;

    typedef struct {
        logic         id;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] dq;
        logic [W-1:0] dr;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic dz, input logic to);
        exp_t e;
        e.id = id; e.q = q; e.r = r; e.dz = dz; e.to = to;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and score any response presented there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got resp_valid=1 id=%0d expected no response", resp_id);
            end else begin
                e = sb.pop_front();
                chk1("resp_id", resp_id, e.id);
                chkw("resp_quotient", resp_quotient, e.q);
                chkw("resp_remainder", resp_remainder, e.r);
                chk1("resp_dz", resp_dz, e.dz);
                chk1("resp_timeout", resp_timeout, e.to);
            end
        end
    endtask

    task automatic wait_grant(output logic got, output logic gid);
        got = 1'b0;
        gid = 1'bx;
        #1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                gid = req1_ready;
            end else begin
                tick();
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no ready within 20 cycles expected a grant");
        end
    endtask

    task automatic drive_req(input logic id, input logic sgn, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_signed = sgn; req1_dividend = a; req1_divisor = b;
        end else begin
            req0_valid = 1'b1; req0_signed = sgn; req0_dividend = a; req0_divisor = b;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic got, gid;
        drive_req(v.id, v.sgn, v.a, v.b);
        wait_grant(got, gid);
        chk1("grant_id", gid, v.id);
        push_exp(v.id, v.eq, v.er, v.edz, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (v.edz) begin
            chk1("dz_resp_at_T1", resp_valid, 1'b1);
            chk1("dz_no_start", div_start_o, 1'b0);
        end else begin
            chk1("start_at_T1", div_start_o, 1'b1);
            chkw("opdata1", div_opdata1_o, v.a);
            chkw("opdata2", div_opdata2_o, v.b);
            chk1("div_signed", div_signed_o, v.sgn);
            for (int c = 1; c < v.lat; c++) tick();
            div_ready_i = 1'b1; div_quotient_i = v.dq; div_remainder_i = v.dr;
            tick();
            div_ready_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
            chk1("resp_at_Tk1", resp_valid, 1'b1);
            chk1("start_low_in_resp", div_start_o, 1'b0);
        end
        tick();
        chk1("idle_after_resp", busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got, gid;
        vecs[0] = '{1'b0, 1'b1, 24'd100,     24'hFFFFF9, 5, 24'hFFFFF2, 24'd2,      24'hFFFFF2, 24'd2,      1'b0};
        vecs[1] = '{1'b1, 1'b0, 24'h00ABCD,  24'h000000, 0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h00ABCD, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 24'd1000,    24'd10,     2, 24'd100,    24'd0,      24'd100,    24'd0,      1'b0};
        vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF,  24'd1,      1, 24'hFFFFFF, 24'd0,      24'hFFFFFF, 24'd0,      1'b0};
        vecs[4] = '{1'b0, 1'b1, 24'h800000,  24'h000000, 0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h800000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 24'hFFFFF6,  24'd3,      7, 24'hFFFFFD, 24'hFFFFFF, 24'hFFFFFD, 24'hFFFFFF, 1'b0};

        rst = 1'b0;
        req0_valid = 1'b0; req0_signed = 1'b0; req0_dividend = '0; req0_divisor = '0; req0_cancel = 1'b0;
        req1_valid = 1'b0; req1_signed = 1'b0; req1_dividend = '0; req1_divisor = '0; req1_cancel = 1'b0;
        div_ready_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
        #1;
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_start", div_start_o, 1'b0);
        chk1("rst_annul", div_annul_o, 1'b0);
        chkw("rst_quotient", resp_quotient, 24'h000000);
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Non-owner cancel is ignored and the operation completes.
        drive_req(1'b0, 1'b0, 24'd20, 24'd4);
        wait_grant(got, gid);
        push_exp(1'b0, 24'd5, 24'd0, 1'b0, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        req1_cancel = 1'b1;
        tick();
        req1_cancel = 1'b0;
        chk1("nonowner_no_annul", div_annul_o, 1'b0);
        chk1("nonowner_still_start", div_start_o, 1'b1);
        div_ready_i = 1'b1; div_quotient_i = 24'd5; div_remainder_i = 24'd0;
        tick();
        div_ready_i = 1'b0;
        chk1("nonowner_resp", resp_valid, 1'b1);
        tick();

        // Owner cancel at T+3: annul at T+4, idle at T+5, no response.
        drive_req(1'b0, 1'b0, 24'd50, 24'd5);
        wait_grant(got, gid);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        req0_cancel = 1'b1;
        tick();
        req0_cancel = 1'b0;
        chk1("cancel_annul_T4", div_annul_o, 1'b1);
        chk1("cancel_start_T4", div_start_o, 1'b0);
        tick();
        chk1("cancel_busy_T5", busy_o, 1'b0);
        chk1("cancel_annul_T5", div_annul_o, 1'b0);

        // Cancel coincident with div ready: no response.
        drive_req(1'b1, 1'b0, 24'd9, 24'd3);
        wait_grant(got, gid);
        tick();
        req1_valid = 1'b0;
        tick();
        req1_cancel = 1'b1; div_ready_i = 1'b1; div_quotient_i = 24'd3;
        tick();
        req1_cancel = 1'b0; div_ready_i = 1'b0; div_quotient_i = '0;
        chk1("coinc_annul", div_annul_o, 1'b1);
        chk1("coinc_no_resp", resp_valid, 1'b0);
        tick();
        chk1("coinc_idle", busy_o, 1'b0);
        tick();

        // Watchdog: last BUSY at T+8, ANNUL at T+9, timeout response at T+10.
        drive_req(1'b1, 1'b0, 24'd77, 24'd7);
        wait_grant(got, gid);
        push_exp(1'b1, 24'd0, 24'd0, 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        for (int c = 2; c <= TO; c++) tick();
        chk1("wd_last_busy_start", div_start_o, 1'b1);
        chk1("wd_last_busy_annul", div_annul_o, 1'b0);
        tick();
        chk1("wd_annul_T9", div_annul_o, 1'b1);
        chk1("wd_start_T9", div_start_o, 1'b0);
        tick();
        chk1("wd_resp_T10", resp_valid, 1'b1);
        tick();

        // Reset in the middle of a req0 operation.
        drive_req(1'b0, 1'b1, 24'd30, 24'd3);
        wait_grant(got, gid);
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk1("midrst_start", div_start_o, 1'b0);
        chk1("midrst_annul", div_annul_o, 1'b0);
        chk1("midrst_resp", resp_valid, 1'b0);
        chk1("midrst_busy", busy_o, 1'b0);
        chkw("midrst_opdata1", div_opdata1_o, 24'h000000);
        tick();
        rst = 1'b1;

        // Contention: both always valid, grants alternate starting with req0.
        drive_req(1'b0, 1'b0, 24'h000111, 24'h000000);
        drive_req(1'b1, 1'b0, 24'h000222, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            logic exp_id;
            exp_id = (i % 2 == 1);
            wait_grant(got, gid);
            chk1("rr_grant", gid, exp_id);
            push_exp(exp_id, 24'hFFFFFF, exp_id ? 24'h000222 : 24'h000111, 1'b1, 1'b0);
            tick();
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding responses expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
